derived_clk_sampler: RTL and testbench

DERIVED_CLK_SAMPLER -- requirements
Module: derived_clk_sampler

---
 rtl/derived_clk_sampler.sv | 135 +++++++++++++
 tb/tb_derived_clk_sampler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/derived_clk_sampler.sv
// derived_clk_sampler
// One free-running shared counter (sub_cnt) plus CHANNELS independent
// divided clocks. Each rising edge of a divided clock samples the counter;
// an all-ones sample counts as a hit. A cycle counter raises a sticky done
// flag after TERM clocks.
module derived_clk_sampler #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 2,
  parameter int DIV_W      = 4,
  parameter int HIT_W      = 4,
  parameter int SAMPLE_NEW = 0,
  parameter int TERM       = 10
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS*DIV_W-1:0] div,
  output logic [CHANNELS-1:0]       sub_clk,
  output logic [CNT_W-1:0]          sub_cnt,
  output logic [CHANNELS-1:0]       hit,
  output logic [CHANNELS*HIT_W-1:0] hit_cnt,
  output logic                      done
);

  localparam int CYC_W = (TERM < 1) ? 1 : $clog2(TERM + 1);
  localparam logic [CYC_W-1:0] TERM_C  = CYC_W'(TERM);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  // Saturating increment for the per-channel hit counters.
  function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] v);
    return (v == HIT_MAX) ? v : v + HIT_W'(1);
  endfunction

  // Saturating increment for the terminal cycle counter.
  function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] v);
    return (v >= TERM_C) ? v : v + CYC_W'(1);
  endfunction

  logic [CHANNELS-1:0][DIV_W-1:0] div_v;

  logic [CNT_W-1:0]               sub_cnt_q, sub_cnt_d;
  logic [CHANNELS-1:0]            sub_clk_q, sub_clk_d;
  logic [CHANNELS-1:0][DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CHANNELS-1:0]            hit_q, hit_d;
  logic [CHANNELS-1:0][HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CYC_W-1:0]               cyc_q, cyc_d;
  logic                           done_q, done_d;

  logic [CHANNELS-1:0]            rise;
  logic [CNT_W-1:0]               sample;
  logic                           sample_hit;

  assign div_v = div;

  // Shared counter next state and the value a rising edge would capture.
  // The sample is formed from registered state only, so there is no race
  // with the counter update on the same edge.
  always_comb begin
    sub_cnt_d = sub_cnt_q;
    if (en) begin
      sub_cnt_d = sub_cnt_q + CNT_W'(1);
    end
    sample     = (SAMPLE_NEW != 0) ? (sub_cnt_q + CNT_W'(1)) : sub_cnt_q;
    sample_hit = &sample;
  end

  // Per-channel divider: a >= compare means lowering div below the running
  // count toggles on the next enabled edge instead of wrapping around.
  always_comb begin
    sub_clk_d = sub_clk_q;
    div_cnt_d = div_cnt_q;
    rise      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en) begin
        if (div_cnt_q[i] >= div_v[i]) begin
          sub_clk_d[i] = ~sub_clk_q[i];
          div_cnt_d[i] = '0;
          rise[i]      = ~sub_clk_q[i];
        end else begin
          div_cnt_d[i] = div_cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Hit flags and counters; clr wins over a hit landing on the same edge.
  always_comb begin
    hit_d     = hit_q;
    hit_cnt_d = hit_cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr) begin
        hit_d[i]     = 1'b0;
        hit_cnt_d[i] = '0;
      end else if (rise[i] && sample_hit) begin
        hit_d[i]     = 1'b1;
        hit_cnt_d[i] = hit_sat_inc(hit_cnt_q[i]);
      end
    end
  end

  // Cycle counter runs regardless of en; done latches once TERM is reached.
  always_comb begin
    cyc_d  = cyc_sat_inc(cyc_q);
    done_d = done_q | (cyc_d == TERM_C);
  end

  // State registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      sub_cnt_q <= '0;
      sub_clk_q <= '0;
      div_cnt_q <= '0;
      hit_q     <= '0;
      hit_cnt_q <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      sub_cnt_q <= sub_cnt_d;
      sub_clk_q <= sub_clk_d;
      div_cnt_q <= div_cnt_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
    end
  end

  assign sub_cnt = sub_cnt_q;
  assign sub_clk = sub_clk_q;
  assign hit     = hit_q;
  assign hit_cnt = hit_cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_derived_clk_sampler.sv
// Bench for derived_clk_sampler: two instances (old-sample and new-sample
// variants) share one stimulus stream and are compared each edge against a
// behavioural model, with extra directed checks of the documented scenarios.
module tb_derived_clk_sampler;

  localparam int CH   = 2;
  localparam int CW   = 2;
  localparam int DW   = 4;
  localparam int HW   = 4;
  localparam int TERM = 10;

  logic clk = 1'b0;
  logic reset_l, en, clr;
  logic [CH*DW-1:0] div;

  logic [CH-1:0]    sub_clk0, sub_clk1, hit0, hit1;
  logic [CW-1:0]    sub_cnt0, sub_cnt1;
  logic [CH*HW-1:0] hit_cnt0, hit_cnt1;
  logic             done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  derived_clk_sampler #(.CHANNELS(CH), .CNT_W(CW), .DIV_W(DW), .HIT_W(HW),
                        .SAMPLE_NEW(0), .TERM(TERM)) u_dut0 (
    .clk(clk), .reset_l(reset_l), .en(en), .clr(clr), .div(div),
    .sub_clk(sub_clk0), .sub_cnt(sub_cnt0), .hit(hit0),
    .hit_cnt(hit_cnt0), .done(done0)
  );

  derived_clk_sampler #(.CHANNELS(CH), .CNT_W(CW), .DIV_W(DW), .HIT_W(HW),
                        .SAMPLE_NEW(1), .TERM(TERM)) u_dut1 (
    .clk(clk), .reset_l(reset_l), .en(en), .clr(clr), .div(div),
    .sub_clk(sub_clk1), .sub_cnt(sub_cnt1), .hit(hit1),
    .hit_cnt(hit_cnt1), .done(done1)
  );

  // Behavioural model: counts of edges and simple integer bookkeeping.
  int m_cnt;
  int m_dc   [CH];
  bit m_clk  [CH];
  bit m_hit  [2][CH];
  int m_hc   [2][CH];
  int m_cyc;
  bit m_done;

  task automatic model_reset();
    m_cnt = 0; m_cyc = 0; m_done = 0;
    for (int c = 0; c < CH; c++) begin
      m_dc[c] = 0; m_clk[c] = 0;
      for (int s = 0; s < 2; s++) begin
        m_hit[s][c] = 0; m_hc[s][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    int pre;
    int smp;
    bit rise;
    int lim;
    if (!reset_l) begin
      model_reset();
      return;
    end
    lim = (1 << HW) - 1;
    if (m_cyc < TERM) m_cyc++;
    if (m_cyc == TERM) m_done = 1;
    pre = m_cnt;
    for (int c = 0; c < CH; c++) begin
      rise = 0;
      if (en) begin
        if (m_dc[c] >= int'(div[c*DW +: DW])) begin
          rise = !m_clk[c];
          m_clk[c] = !m_clk[c];
          m_dc[c] = 0;
        end else begin
          m_dc[c]++;
        end
      end
      for (int s = 0; s < 2; s++) begin
        smp = (s == 0) ? pre : (pre + 1) % (1 << CW);
        if (clr) begin
          m_hit[s][c] = 0;
          m_hc[s][c]  = 0;
        end else if (rise && smp == (1 << CW) - 1) begin
          m_hit[s][c] = 1;
          m_hc[s][c]  = (m_hc[s][c] < lim) ? m_hc[s][c] + 1 : lim;
        end
      end
    end
    if (en) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH-1:0]    e_clk;
    logic [CH-1:0]    e_hit [2];
    logic [CH*HW-1:0] e_hc  [2];
    for (int c = 0; c < CH; c++) begin
      e_clk[c] = m_clk[c];
      for (int s = 0; s < 2; s++) begin
        e_hit[s][c] = m_hit[s][c];
        e_hc[s][c*HW +: HW] = HW'(m_hc[s][c]);
      end
    end
    chk({tag, " d0 sub_clk"}, 32'(sub_clk0), 32'(e_clk));
    chk({tag, " d0 sub_cnt"}, 32'(sub_cnt0), 32'(m_cnt));
    chk({tag, " d0 hit"},     32'(hit0),     32'(e_hit[0]));
    chk({tag, " d0 hit_cnt"}, 32'(hit_cnt0), 32'(e_hc[0]));
    chk({tag, " d0 done"},    32'(done0),    32'(m_done));
    chk({tag, " d1 sub_clk"}, 32'(sub_clk1), 32'(e_clk));
    chk({tag, " d1 sub_cnt"}, 32'(sub_cnt1), 32'(m_cnt));
    chk({tag, " d1 hit"},     32'(hit1),     32'(e_hit[1]));
    chk({tag, " d1 hit_cnt"}, 32'(hit_cnt1), 32'(e_hc[1]));
    chk({tag, " d1 done"},    32'(done1),    32'(m_done));
  endtask

  // One clock edge: update the model from the inputs held across the edge,
  // then sample the DUT outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    reset_l = 1'b0; en = 1'b0; clr = 1'b0; div = '0;

    // Reset state
    step("rst1");
    step("rst2");
    chk("rst sub_cnt", 32'(sub_cnt0), 32'd0);
    chk("rst done", 32'(done1), 32'd0);

    // Free-running, div=0: rises at odd edges; new-sample variant hits
    reset_l = 1'b1; en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step($sformatf("run e%0d", n));
      if (n == 1) begin
        chk("e1 sub_cnt", 32'(sub_cnt0), 32'd1);
        chk("e1 sub_clk0", 32'(sub_clk0[0]), 32'd1);
      end
      if (n == 2) chk("e2 hit1", 32'(hit1[0]), 32'd0);
      if (n == 3) begin
        chk("e3 hit1", 32'(hit1[0]), 32'd1);
        chk("e3 hit_cnt1", 32'(hit_cnt1[3:0]), 32'd1);
      end
      if (n == 9)  chk("e9 done", 32'(done0), 32'd0);
      if (n == 10) chk("e10 done", 32'(done0), 32'd1);
    end
    chk("old-sample hit", 32'(hit0), 32'd0);
    chk("old-sample hit_cnt", 32'(hit_cnt0), 32'd0);
    chk("new-sample hit_cnt ch0", 32'(hit_cnt1[3:0]), 32'd4);

    // div ch1 = 1: toggles at even edges; lowering div retoggles next edge
    reset_l = 1'b0; step("rst3");
    reset_l = 1'b1; div = {4'd1, 4'd0};
    step("d1 e1"); chk("d1 e1 clk1", 32'(sub_clk0[1]), 32'd0);
    step("d1 e2"); chk("d1 e2 clk1", 32'(sub_clk0[1]), 32'd1);
    step("d1 e3"); chk("d1 e3 clk1", 32'(sub_clk0[1]), 32'd1);
    div = {4'd0, 4'd0};
    step("d1 e4"); chk("d1 e4 clk1", 32'(sub_clk0[1]), 32'd0);
    reset_l = 1'b0; step("rst4");
    reset_l = 1'b1; div = {4'd3, 4'd0};
    step("d3 e1");
    step("d3 e2"); chk("d3 e2 clk1", 32'(sub_clk0[1]), 32'd0);
    div = {4'd1, 4'd0};
    step("d3 e3"); chk("lowered div toggle", 32'(sub_clk0[1]), 32'd1);

    // en low for 5 edges mid-run; done still at edge 10
    reset_l = 1'b0; step("rst5");
    reset_l = 1'b1; div = '0; en = 1'b1;
    for (int n = 1; n <= 3; n++) step($sformatf("en e%0d", n));
    en = 1'b0;
    for (int n = 4; n <= 8; n++) begin
      step($sformatf("hold e%0d", n));
      chk("hold sub_cnt", 32'(sub_cnt0), 32'd3);
      chk("hold sub_clk0", 32'(sub_clk0[0]), 32'd1);
      chk("hold hit_cnt1", 32'(hit_cnt1[3:0]), 32'd1);
    end
    en = 1'b1;
    step("en e9");  chk("gap e9 done", 32'(done0), 32'd0);
    step("en e10"); chk("gap e10 done", 32'(done0), 32'd1);
    step("en e11"); chk("gap e11 done", 32'(done1), 32'd1);

    // clr on edge 3 beats the coincident hit; saturation on long run
    reset_l = 1'b0; step("rst6");
    reset_l = 1'b1;
    step("clr e1"); step("clr e2");
    clr = 1'b1;
    step("clr e3");
    clr = 1'b0;
    chk("clr e3 hit1", 32'(hit1[0]), 32'd0);
    chk("clr e3 hit_cnt1", 32'(hit_cnt1[3:0]), 32'd0);
    chk("clr e3 sub_cnt", 32'(sub_cnt1), 32'd3);
    for (int n = 4; n <= 7; n++) step($sformatf("clr e%0d", n));
    chk("clr e7 hit_cnt1", 32'(hit_cnt1[3:0]), 32'd1);
    for (int n = 8; n <= 80; n++) step($sformatf("sat e%0d", n));
    chk("saturated hit_cnt1", 32'(hit_cnt1[3:0]), 32'd15);

    // Reset mid-operation at edge 6 then restart
    reset_l = 1'b0; step("rst7");
    reset_l = 1'b1;
    for (int n = 1; n <= 5; n++) step($sformatf("mr e%0d", n));
    reset_l = 1'b0;
    step("mr e6");
    chk("mr sub_cnt", 32'(sub_cnt0), 32'd0);
    chk("mr sub_clk", 32'(sub_clk1), 32'd0);
    chk("mr hit1", 32'(hit1), 32'd0);
    chk("mr hit_cnt1", 32'(hit_cnt1), 32'd0);
    reset_l = 1'b1;
    step("mr r1");
    chk("mr r1 sub_cnt", 32'(sub_cnt0), 32'd1);
    chk("mr r1 sub_clk0", 32'(sub_clk0[0]), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset_l = ($urandom_range(0, 59) != 0);
      en      = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < CH; c++) begin
          div[c*DW +: DW] = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 15))
                                                        : DW'($urandom_range(0, 3));
        end
      end
      step($sformatf("rnd %0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
